// File: rtl/mgt_01_div_ip.sv
// Iterative radix-2 divide/remainder unit for the RV32IM execute stage.
// Handles DIV/DIVU/REM/REMU with RISC-V M results for divide-by-zero and signed overflow.
// ops_i encoding: 0 DIV_, 1 DIVU_, 2 REM_, 3 REMU_. bit0 set = unsigned, bit1 set = remainder.
// fu_state_o encoding: 0 FREE, 1 BUSY, 2 VALID.
module mgt_01_div_ip (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clk_en_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        is_division_i,
  input  logic [1:0]  ops_i,
  output logic [31:0] result_o,
  output logic        div_by_zero_o,
  output logic [1:0]  fu_state_o
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    BUSY  = 2'd1,
    VALID = 2'd2
  } fu_state_e;

  fu_state_e          state_q, state_d;
  logic        [5:0]  cnt_q;
  logic        [31:0] rem_q;
  logic        [31:0] quot_q;
  logic        [31:0] dvs_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic               is_rem_q;
  logic               dbz_q;

  logic               start;
  logic               iter;
  logic               finish;
  logic               is_signed_op;
  logic               sign_a;
  logic               sign_b;
  logic        [31:0] abs_a;
  logic        [31:0] abs_b;
  logic        [32:0] shifted;
  logic signed [32:0] diff;
  logic        [31:0] q_final;
  logic        [31:0] r_final;

  // Two's-complement negate when the sign flag is set.
  function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
    apply_sign = neg ? (~mag + 32'd1) : mag;
  endfunction

  // Operand conditioning, one restoring step and final sign correction.
  always_comb begin
    is_signed_op = ~ops_i[0];
    sign_a       = is_signed_op & dividend_i[31];
    sign_b       = is_signed_op & divisor_i[31];
    abs_a        = apply_sign(dividend_i, sign_a);
    abs_b        = apply_sign(divisor_i, sign_b);
    shifted      = {rem_q, quot_q[31]};
    diff         = $signed(shifted) - $signed({1'b0, dvs_q});
    if (dbz_q) begin
      // Divisor zero: quotient all ones, remainder is the original dividend.
      q_final = 32'hFFFF_FFFF;
      r_final = apply_sign(quot_q, neg_a_q);
    end else begin
      q_final = apply_sign(quot_q, neg_a_q ^ neg_b_q);
      r_final = apply_sign(rem_q, neg_a_q);
    end
  end

  // Control qualifiers; nothing advances unless the clock enable is high.
  always_comb begin
    start  = (state_q == FREE) & is_division_i;
    iter   = (state_q == BUSY) & ~dbz_q & (cnt_q != 6'd32);
    finish = (state_q == BUSY) & (dbz_q | (cnt_q == 6'd32));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE:    if (is_division_i) state_d = BUSY;
      BUSY:    if (dbz_q || cnt_q == 6'd32) state_d = VALID;
      VALID:   state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      state_q <= FREE;
    else if (clk_en_i) state_q <= state_d;
  end

  // Datapath: latch operands on start, iterate in BUSY, publish on the correction edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q         <= 6'd0;
      rem_q         <= 32'd0;
      quot_q        <= 32'd0;
      dvs_q         <= 32'd0;
      neg_a_q       <= 1'b0;
      neg_b_q       <= 1'b0;
      is_rem_q      <= 1'b0;
      dbz_q         <= 1'b0;
      result_o      <= 32'd0;
      div_by_zero_o <= 1'b0;
    end else if (clk_en_i) begin
      if (start) begin
        cnt_q    <= 6'd0;
        rem_q    <= 32'd0;
        quot_q   <= abs_a;
        dvs_q    <= abs_b;
        neg_a_q  <= sign_a;
        neg_b_q  <= sign_b;
        is_rem_q <= ops_i[1];
        dbz_q    <= (divisor_i == 32'd0);
      end
      if (iter) begin
        cnt_q <= cnt_q + 6'd1;
        if (!diff[32]) begin
          rem_q  <= diff[31:0];
          quot_q <= {quot_q[30:0], 1'b1};
        end else begin
          rem_q  <= shifted[31:0];
          quot_q <= {quot_q[30:0], 1'b0};
        end
      end
      if (finish) begin
        result_o      <= is_rem_q ? r_final : q_final;
        div_by_zero_o <= dbz_q;
      end
    end
  end

  assign fu_state_o = state_q;

endmodule

// File: tb/tb_mgt_01_div_ip.sv
// Testbench for mgt_01_div_ip: vector table, scoreboard queue, stall/reset/back-to-back sequences.
module tb_mgt_01_div_ip;

  localparam logic [1:0] DIV_ = 2'd0, DIVU_ = 2'd1, REM_ = 2'd2, REMU_ = 2'd3;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_VALID = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        is_div = 1'b0;
  logic [1:0]  ops = '0;
  logic [31:0] result;
  logic        dbz;
  logic [1:0]  fu_state;

  mgt_01_div_ip dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clk_en_i      (clk_en),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .is_division_i (is_div),
    .ops_i         (ops),
    .result_o      (result),
    .div_by_zero_o (dbz),
    .fu_state_o    (fu_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          lat;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];
  int   passed = 0;
  int   total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %h, required %h", nm, act, req);
    else passed++;
  endtask

  task automatic timeout(input string nm);
    total++;
    $display("FAIL %s: no VALID within cycle budget", nm);
  endtask

  // Run one op; optionally drop clk_en for stall_len edges after edge stall_at.
  task automatic run_op(input vec_t v, input int stall_at, input int stall_len);
    int   cyc;
    bit   done;
    exp_t e;
    @(negedge clk);
    dividend = v.a; divisor = v.b; ops = v.op; is_div = 1'b1; clk_en = 1'b1;
    sb.push_back('{res: v.res, dz: v.dz, lat: v.lat + stall_len});
    cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        is_div = 1'b0;
        check({v.nm, " busy_after_start"}, {30'd0, fu_state}, {30'd0, S_BUSY});
      end
      if (fu_state == S_VALID) done = 1'b1;
      else begin
        @(negedge clk);
        clk_en = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      end
    end
    clk_en = 1'b1;
    e = sb.pop_front();
    if (!done) timeout(v.nm);
    else begin
      check({v.nm, " result"}, result, e.res);
      check({v.nm, " div_by_zero"}, {31'd0, dbz}, {31'd0, e.dz});
      check({v.nm, " latency"}, cyc, e.lat);
      @(posedge clk); #1;
      check({v.nm, " free_after_valid"}, {30'd0, fu_state}, {30'd0, S_FREE});
      check({v.nm, " result_held"}, result, e.res);
    end
  endtask

  initial begin
    vec_t v;
    int   cyc, t1, t2, nvalid;
    bit   saw_valid;
    exp_t e;

    vecs[0]  = '{"div_100_5",      32'd100,        32'd5,          DIV_,  32'd20,         1'b0, 34};
    vecs[1]  = '{"rem_900_5",      32'd900,        32'd5,          REM_,  32'd0,          1'b0, 34};
    vecs[2]  = '{"div_m80_5",      32'hFFFF_FFB0,  32'd5,          DIV_,  32'hFFFF_FFF0,  1'b0, 34};
    vecs[3]  = '{"rem_m402_5",     32'hFFFF_FE6E,  32'd5,          REM_,  32'hFFFF_FFFE,  1'b0, 34};
    vecs[4]  = '{"div_m402_5",     32'hFFFF_FE6E,  32'd5,          DIV_,  32'hFFFF_FFB0,  1'b0, 34};
    vecs[5]  = '{"div_m80_0",      32'hFFFF_FFB0,  32'd0,          DIV_,  32'hFFFF_FFFF,  1'b1, 2};
    vecs[6]  = '{"rem_m80_0",      32'hFFFF_FFB0,  32'd0,          REM_,  32'hFFFF_FFB0,  1'b1, 2};
    vecs[7]  = '{"divu_big_8",     32'hFFFF_FFDF,  32'd8,          DIVU_, 32'h1FFF_FFFB,  1'b0, 34};
    vecs[8]  = '{"remu_big_8",     32'hFFFF_FFDF,  32'd8,          REMU_, 32'd7,          1'b0, 34};
    vecs[9]  = '{"divu_0_8",       32'd0,          32'd8,          DIVU_, 32'd0,          1'b0, 34};
    vecs[10] = '{"div_ovf",        32'h8000_0000,  32'hFFFF_FFFF,  DIV_,  32'h8000_0000,  1'b0, 34};
    vecs[11] = '{"rem_ovf",        32'h8000_0000,  32'hFFFF_FFFF,  REM_,  32'd0,          1'b0, 34};
    vecs[12] = '{"div_7_m2",       32'd7,          32'hFFFF_FFFE,  DIV_,  32'hFFFF_FFFD,  1'b0, 34};
    vecs[13] = '{"rem_7_m2",       32'd7,          32'hFFFF_FFFE,  REM_,  32'd1,          1'b0, 34};
    vecs[14] = '{"remu_7_0",       32'd7,          32'd0,          REMU_, 32'd7,          1'b1, 2};

    // Reset state
    #12;
    check("reset_state", {30'd0, fu_state}, {30'd0, S_FREE});
    check("reset_result", result, 32'd0);
    check("reset_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_op(vecs[i], 0, 0);

    // Stall mid-BUSY: 5 disabled edges extend latency by 5
    v = vecs[2]; v.nm = "stall_div_m80_5";
    run_op(v, 10, 5);
    v = vecs[7]; v.nm = "stall_divu_big_8";
    run_op(v, 3, 7);

    // Back-to-back with is_division held high: VALIDs 35 cycles apart
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd10; ops = DIVU_; is_div = 1'b1;
    sb.push_back('{res: 32'd100, dz: 1'b0, lat: 34});
    sb.push_back('{res: 32'd100, dz: 1'b0, lat: 35});
    cyc = 0; t1 = 0; t2 = 0; nvalid = 0;
    while (nvalid < 2 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (fu_state == S_VALID) begin
        nvalid++;
        e = sb.pop_front();
        check("b2b result", result, e.res);
        if (nvalid == 1) begin t1 = cyc; check("b2b first_latency", t1, e.lat); end
        else begin t2 = cyc; check("b2b period", t2 - t1, e.lat); is_div = 1'b0; end
      end
    end
    is_div = 1'b0;
    if (nvalid < 2) begin
      timeout("b2b");
      sb.delete();
    end

    // Reset mid-BUSY aborts with no result
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd5; ops = DIV_; is_div = 1'b1;
    @(posedge clk); #1; is_div = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("abort_state", {30'd0, fu_state}, {30'd0, S_FREE});
    check("abort_result", result, 32'd0);
    check("abort_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (fu_state != S_FREE) saw_valid = 1'b1;
    end
    check("abort_stays_free", {31'd0, saw_valid}, 32'd0);
    v = vecs[0]; v.nm = "after_abort_div";
    run_op(v, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
